// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 step per cycle on operand magnitudes. Signs are restored when
// the result is formed. Outputs are all registered. Divide-by-zero and signed
// overflow skip the iteration and finish two cycles after issue.
module mul_div_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [DATA_WIDTH-1:0]    a,
    input  logic [DATA_WIDTH-1:0]    b,
    input  logic [ADDRESS_WIDTH-1:0] rd_in,
    input  logic                     flush,
    output logic                     busy,
    output logic                     done,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] rd_out,
    output logic [DATA_WIDTH-1:0]    result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q;
    logic [2*W-1:0] prod;      // multiply: {accumulator, multiplier}; divide: {remainder, quotient}
    logic [W-1:0]  mcand;      // multiplicand magnitude or divisor magnitude
    logic [CW-1:0] cnt;
    logic          neg_res;    // product / quotient needs negation
    logic          neg_rem;    // remainder needs negation (dividend was negative)
    logic          div_zero;
    logic          div_ovf;

    // Operand decode at issue: signedness, magnitudes and the special cases
    logic         a_signed, b_signed, a_neg, b_neg, is_zero, is_ovf;
    logic [W-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed = op[2] ? ~op[0] : ~op[1];
        a_neg    = a_signed & a[W-1];
        b_neg    = b_signed & b[W-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        is_zero  = op[2] && (b == '0);
        is_ovf   = op[2] && !op[0] && (a == MIN_NEG) && (b == ALL_ONES);
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    logic [W:0]     mul_sum;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] step_next;

    always_comb begin
        mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        div_diff = {1'b0, prod[2*W-1:W], prod[W-1]} - {2'b00, mcand};
        if (op_q[2]) begin
            if (!div_diff[W+1])
                step_next = {div_diff[W-1:0], prod[W-2:0], 1'b1};
            else
                step_next = {prod[2*W-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, prod[W-1:1]};
        end
    end

    // Sign correction and result selection from the finished product/quotient
    function automatic logic [W-1:0] select_result(
        input logic [2:0]     f,
        input logic [2*W-1:0] p,
        input logic           nr,
        input logic           nm,
        input logic           dz,
        input logic           ov,
        input logic [W-1:0]   dividend
    );
        logic [2*W-1:0] p_fix;
        logic [W-1:0]   quo;
        logic [W-1:0]   rem;
        p_fix = nr ? -p : p;
        quo   = nr ? -p[W-1:0] : p[W-1:0];
        rem   = nm ? -p[2*W-1:W] : p[2*W-1:W];
        if (dz)
            select_result = f[1] ? dividend : ALL_ONES;
        else if (ov)
            select_result = f[1] ? '0 : MIN_NEG;
        else if (!f[2])
            select_result = (f[1:0] == 2'b00) ? p_fix[W-1:0] : p_fix[2*W-1:W];
        else
            select_result = f[1] ? rem : quo;
    endfunction

    // Control FSM with registered outputs and iterative datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            prod     <= '0;
            mcand    <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            we       <= 1'b0;
            rd_out   <= '0;
            result   <= '0;
        end else if (flush && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    we   <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        a_q      <= a;
                        rd_out   <= rd_in;
                        busy     <= 1'b1;
                        cnt      <= CW'(W - 1);
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= is_zero;
                        div_ovf  <= is_ovf;
                        if (op[2]) begin
                            prod  <= {{W{1'b0}}, a_mag};
                            mcand <= b_mag;
                        end else begin
                            prod  <= {{W{1'b0}}, b_mag};
                            mcand <= a_mag;
                        end
                        state <= (is_zero || is_ovf) ? DONE : CALC;
                    end
                end
                CALC: begin
                    prod <= step_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= DONE;
                end
                DONE: begin
                    // First cycle forms the result and raises done; second retires
                    if (!done) begin
                        result <= select_result(op_q, prod, neg_res, neg_rem,
                                                div_zero, div_ovf, a_q);
                        done   <= 1'b1;
                        we     <= (rd_out != '0);
                    end else begin
                        done  <= 1'b0;
                        we    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd_in;
    logic        busy, done, we;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int cmp_cnt = 0;
    int err_cnt = 0;

    mul_div_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .we(we),
        .rd_out(rd_out), .result(result)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for its done strobe.
    // lat counts rising edges from the issuing edge up to the done cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] r, output logic [31:0] res, output logic w,
                          output logic [4:0] ro, output logic bsy, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; rd_in = r;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; res = '0; w = 1'b0; ro = '0; bsy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                res = result; w = we; ro = rd_out; bsy = busy;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        cmp_cnt++;
        if ({busy, done, we, rd_out, result} !== 40'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got busy=%b done=%b we=%b rd=%0d res=%h, want all 0",
                     busy, done, we, rd_out, result);
        end
    endtask

    task automatic test_mul();
        logic [31:0] res; logic w, bsy; logic [4:0] ro; int lat;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, res, w, ro, bsy, lat);
        cmp_cnt++;
        if (res !== 32'hFFFF_FFEB) begin err_cnt++; $display("FAIL mul_result: got %h want ffffffeb", res); end
        cmp_cnt++;
        if (lat !== 34) begin err_cnt++; $display("FAIL mul_latency: got %0d want 34", lat); end
        cmp_cnt++;
        if ({w, ro, bsy} !== {1'b1, 5'd5, 1'b1}) begin
            err_cnt++; $display("FAIL mul_we_rd_busy: got we=%b rd=%0d busy=%b want 1/5/1", w, ro, bsy);
        end
        @(negedge clk);
        cmp_cnt++;
        if ({done, we, busy} !== 3'b000) begin
            err_cnt++; $display("FAIL mul_retire: got done=%b we=%b busy=%b want 000", done, we, busy);
        end
        run_op(3'd0, 32'h0001_0003, 32'h0001_0005, 5'd1, res, w, ro, bsy, lat);
        cmp_cnt++;
        if (res !== 32'h0008_000F) begin err_cnt++; $display("FAIL mul_low: got %h want 0008000f", res); end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [4] = '{3'd1, 3'd3, 3'd2, 3'd1};
        logic [31:0] va  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] res; logic w, bsy; logic [4:0] ro; int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], 5'd2, res, w, ro, bsy, lat);
            cmp_cnt++;
            if (res !== exp[i] || lat !== 34) begin
                err_cnt++;
                $display("FAIL mulh_vec%0d: got %h lat %0d want %h lat 34", i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] va  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb  [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                                 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h10, 32'h10};
        logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFD, 32'd1, 32'h0FFF_FFFF, 32'hF};
        logic [31:0] res; logic w, bsy; logic [4:0] ro; int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], va[i], vb[i], 5'd3, res, w, ro, bsy, lat);
            cmp_cnt++;
            if (res !== exp[i] || lat !== 34) begin
                err_cnt++;
                $display("FAIL div_vec%0d: got %h lat %0d want %h lat 34", i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] va  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res; logic w, bsy; logic [4:0] ro; int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], va[i], vb[i], 5'd4, res, w, ro, bsy, lat);
            cmp_cnt++;
            if (res !== exp[i] || lat !== 2) begin
                err_cnt++;
                $display("FAIL special_vec%0d: got %h lat %0d want %h lat 2", i, res, lat, exp[i]);
            end
        end
        run_op(3'd4, 32'h8000_0000, 32'd1, 5'd4, res, w, ro, bsy, lat);
        cmp_cnt++;
        if (res !== 32'h8000_0000 || lat !== 34) begin
            err_cnt++; $display("FAIL div_min_by_one: got %h lat %0d want 80000000 lat 34", res, lat);
        end
    endtask

    task automatic test_rd_zero();
        logic [31:0] res; logic w, bsy; logic [4:0] ro; int lat;
        run_op(3'd0, 32'd3, 32'd4, 5'd0, res, w, ro, bsy, lat);
        cmp_cnt++;
        if (res !== 32'd12 || w !== 1'b0 || lat !== 34) begin
            err_cnt++; $display("FAIL rd_zero: got res=%h we=%b lat=%0d want 0000000c/0/34", res, w, lat);
        end
    endtask

    task automatic test_back_to_back();
        int n_done; logic [31:0] res;
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; res = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin n_done++; res = result; end
        end
        cmp_cnt++;
        if (n_done !== 1) begin err_cnt++; $display("FAIL b2b_done_count: got %0d want 1", n_done); end
        cmp_cnt++;
        if (res !== 32'd14 || rd_out !== 5'd9 || result !== 32'd14) begin
            err_cnt++;
            $display("FAIL b2b_result: got done_res=%h rd=%0d res=%h want 0000000e/9/0000000e", res, rd_out, result);
        end
    endtask

    task automatic test_flush();
        int n_done;
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd3; rd_in = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if ({busy, done, we} !== 3'b000) begin
            err_cnt++; $display("FAIL flush_idle: got busy=%b done=%b we=%b want 000", busy, done, we);
        end
        n_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        cmp_cnt++;
        if (n_done !== 0 || result !== 32'd14 || rd_out !== 5'd4) begin
            err_cnt++;
            $display("FAIL flush_no_done: got dones=%0d res=%h rd=%0d want 0/0000000e/4", n_done, result, rd_out);
        end
    endtask

    task automatic test_rst_mid();
        logic [31:0] res; logic w, bsy; logic [4:0] ro; int lat;
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; rd_in = 5'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cmp_cnt++;
        if ({busy, done, we, rd_out, result} !== 40'd0) begin
            err_cnt++;
            $display("FAIL rst_mid: got busy=%b done=%b we=%b rd=%0d res=%h want all 0",
                     busy, done, we, rd_out, result);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, 5'd2, res, w, ro, bsy, lat);
        cmp_cnt++;
        if (res !== 32'd14 || w !== 1'b1 || ro !== 5'd2 || lat !== 34) begin
            err_cnt++;
            $display("FAIL after_rst_op: got res=%h we=%b rd=%0d lat=%0d want 0000000e/1/2/34", res, w, ro, lat);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_rd_zero();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
